// File: rtl/slave_tx_pkg.sv
// rtl/slave_tx_pkg.sv - shared types and constants for the slave stream transmitter
package slave_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FINISH = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_NONE = 2'b00;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  // storage has no reset; readers qualify head with empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/slave_stream_tx.sv
// rtl/slave_stream_tx.sv - descriptor-driven stream transmitter feeding one arbiter slave port
module slave_stream_tx
  import slave_tx_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int LENW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic [1:0]      cfg_mode,
  input  logic [LENW-1:0] cfg_len,
  input  logic            pix_valid,
  input  logic [DW-1:0]   pix_data,
  output logic            pix_ready,
  output logic [1:0]      slv_mode,
  output logic            slv_data_valid,
  output logic            slv_proc_valid,
  output logic [DW-1:0]   slv_data,
  input  logic            slv_ready,
  input  logic            mstr0_cmplt,
  output logic            busy,
  output logic            done,
  output logic            aborted
);

  localparam int AW = $clog2(DEPTH);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      mode_q;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] in_cnt;
  logic [LENW-1:0] out_cnt;

  logic [DW-1:0]   fifo_head;
  logic [AW:0]     fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_flush;

  logic            start_ok;
  logic            active;
  logic            word_valid;
  logic            last_word;
  logic            xfer;
  logic            push;

  assign start_ok   = cfg_start && (cfg_mode != MODE_NONE) && (cfg_len != '0);
  assign active     = (state == ACTIVE);
  assign word_valid = active && !fifo_empty;
  assign last_word  = word_valid && (out_cnt == len_q - 1'b1);
  assign xfer       = word_valid && slv_ready;
  assign push       = pix_valid && pix_ready && !fifo_full;

  assign slv_data_valid = word_valid;
  assign slv_proc_valid = last_word;
  assign slv_data       = word_valid ? fifo_head : '0;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pix_data),
    .pop       (xfer),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // pix_ready depends on registered state only, never on slv_ready
  always_comb begin
    state_nxt  = state;
    slv_mode   = MODE_NONE;
    pix_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    aborted    = 1'b0;
    fifo_flush = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) begin
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        slv_mode  = mode_q;
        pix_ready = (fifo_count < DEPTH[AW:0]) && (in_cnt < len_q);
        if (xfer && last_word) begin
          state_nxt = FINISH;
        end else if (mstr0_cmplt) begin
          state_nxt = FLUSH;
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      FLUSH: begin
        done       = 1'b1;
        aborted    = 1'b1;
        fifo_flush = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_NONE;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if ((state == IDLE) && start_ok) begin
      mode_q  <= cfg_mode;
      len_q   <= cfg_len;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (active) begin
      if (push) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (xfer) begin
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slave_stream_tx.sv
// tb/tb_slave_stream_tx.sv - directed self-checking bench for slave_stream_tx
module tb_slave_stream_tx;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len;
  logic        pix_valid;
  logic [31:0] pix_data;
  logic        pix_ready;
  logic [1:0]  slv_mode;
  logic        slv_data_valid;
  logic        slv_proc_valid;
  logic [31:0] slv_data;
  logic        slv_ready;
  logic        mstr0_cmplt;
  logic        busy;
  logic        done;
  logic        aborted;

  logic [31:0] base;
  logic [31:0] push_idx;
  logic        clr;
  int          mon_cnt;
  int          done_cnt;
  int          abort_cnt;
  logic [31:0] got_data [16];
  logic        got_last [16];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  slave_stream_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .cfg_mode       (cfg_mode),
    .cfg_len        (cfg_len),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .slv_mode       (slv_mode),
    .slv_data_valid (slv_data_valid),
    .slv_proc_valid (slv_proc_valid),
    .slv_data       (slv_data),
    .slv_ready      (slv_ready),
    .mstr0_cmplt    (mstr0_cmplt),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pix_data = base + push_idx;

  // upstream source index and downstream capture
  always @(posedge clk) begin
    if (clr) begin
      push_idx  <= '0;
      mon_cnt   <= 0;
      done_cnt  <= 0;
      abort_cnt <= 0;
    end else begin
      if (pix_valid && pix_ready) push_idx <= push_idx + 1;
      if (slv_data_valid && slv_ready && mon_cnt < 16) begin
        got_data[mon_cnt] <= slv_data;
        got_last[mon_cnt] <= slv_proc_valid;
        mon_cnt <= mon_cnt + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (aborted) abort_cnt <= abort_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tb();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic start(input logic [1:0] mode, input logic [15:0] len);
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_mode  = mode;
    cfg_len   = len;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_mode  = 2'b00;
    cfg_len   = '0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_mode = 2'b00; cfg_len = '0;
    pix_valid = 1'b0; slv_ready = 1'b0; mstr0_cmplt = 1'b0;
    base = 32'h10; clr = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mode", {30'b0, slv_mode}, 32'd0);
    check("rst_valid", {31'b0, slv_data_valid}, 32'd0);
    check("rst_pix_ready", {31'b0, pix_ready}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_data", slv_data, 32'd0);
    rst_n = 1'b1;
    clr = 1'b0;

    // 1: streaming transfer, len 4
    pix_valid = 1'b1; slv_ready = 1'b1; base = 32'h10;
    clear_tb();
    start(2'b01, 16'd4);
    check("t1_busy", {31'b0, busy}, 32'd1);
    check("t1_mode", {30'b0, slv_mode}, 32'd1);
    wait_done(20, cyc);
    check("t1_done_latency", cyc, 32'd5);
    check("t1_aborted", {31'b0, aborted}, 32'd0);
    check("t1_count", mon_cnt, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_data", got_data[i], 32'h10 + i);
      check("t1_last", {31'b0, got_last[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("t1_busy_low", {31'b0, busy}, 32'd0);
    check("t1_done_pulse", {31'b0, done}, 32'd0);

    // 2: backpressure, len 8
    slv_ready = 1'b0; base = 32'h10;
    clear_tb();
    start(2'b10, 16'd8);
    repeat (10) @(negedge clk);
    check("t2_pushed", push_idx, 32'd4);
    check("t2_pix_ready", {31'b0, pix_ready}, 32'd0);
    check("t2_valid", {31'b0, slv_data_valid}, 32'd1);
    check("t2_head", slv_data, 32'h10);
    check("t2_mode", {30'b0, slv_mode}, 32'd2);
    slv_ready = 1'b1;
    wait_done(40, cyc);
    check("t2_done", {31'b0, done}, 32'd1);
    check("t2_count", mon_cnt, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("t2_data", got_data[i], 32'h10 + i);
    end
    check("t2_last7", {31'b0, got_last[7]}, 32'd1);
    check("t2_last6", {31'b0, got_last[6]}, 32'd0);
    @(negedge clk);

    // 3: rejected starts
    clear_tb();
    start(2'b00, 16'd5);
    check("t3_busy_mode0", {31'b0, busy}, 32'd0);
    check("t3_slvmode_mode0", {30'b0, slv_mode}, 32'd0);
    start(2'b01, 16'd0);
    check("t3_busy_len0", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t3_no_done", done_cnt, 32'd0);
    check("t3_pix_ready", {31'b0, pix_ready}, 32'd0);

    // 4: abort after two words, then fresh transfer
    base = 32'h40;
    clear_tb();
    start(2'b11, 16'd6);
    repeat (3) @(negedge clk);
    check("t4_two_sent", mon_cnt, 32'd2);
    slv_ready = 1'b0; mstr0_cmplt = 1'b1;
    @(negedge clk);
    check("t4_mode", {30'b0, slv_mode}, 32'd0);
    check("t4_valid", {31'b0, slv_data_valid}, 32'd0);
    check("t4_pix_ready", {31'b0, pix_ready}, 32'd0);
    check("t4_done", {31'b0, done}, 32'd1);
    check("t4_aborted", {31'b0, aborted}, 32'd1);
    mstr0_cmplt = 1'b0; slv_ready = 1'b1;
    @(negedge clk);
    check("t4_idle", {31'b0, busy}, 32'd0);
    base = 32'h80;
    clear_tb();
    start(2'b01, 16'd2);
    wait_done(20, cyc);
    check("t4_new_latency", cyc, 32'd3);
    check("t4_new_aborted", {31'b0, aborted}, 32'd0);
    check("t4_new_count", mon_cnt, 32'd2);
    check("t4_new_d0", got_data[0], 32'h80);
    check("t4_new_d1", got_data[1], 32'h81);
    @(negedge clk);

    // 5: completion coincident with last word
    base = 32'h50;
    clear_tb();
    start(2'b01, 16'd3);
    repeat (3) @(negedge clk);
    check("t5_two_sent", mon_cnt, 32'd2);
    mstr0_cmplt = 1'b1;
    @(negedge clk);
    mstr0_cmplt = 1'b0;
    check("t5_done", {31'b0, done}, 32'd1);
    check("t5_aborted", {31'b0, aborted}, 32'd0);
    check("t5_count", mon_cnt, 32'd3);
    check("t5_last", {31'b0, got_last[2]}, 32'd1);
    check("t5_last_data", got_data[2], 32'h52);
    @(negedge clk);

    // 6: reset mid-transfer
    base = 32'h60;
    clear_tb();
    start(2'b01, 16'd5);
    repeat (3) @(negedge clk);
    check("t6_two_sent", mon_cnt, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_mode", {30'b0, slv_mode}, 32'd0);
    check("t6_valid", {31'b0, slv_data_valid}, 32'd0);
    check("t6_pix_ready", {31'b0, pix_ready}, 32'd0);
    check("t6_data", slv_data, 32'd0);
    repeat (2) @(negedge clk);
    check("t6_no_done", done_cnt, 32'd0);
    rst_n = 1'b1;
    base = 32'h90;
    clear_tb();
    start(2'b01, 16'd2);
    wait_done(20, cyc);
    check("t6_new_latency", cyc, 32'd3);
    check("t6_new_aborted", {31'b0, aborted}, 32'd0);
    check("t6_new_d0", got_data[0], 32'h90);
    check("t6_new_d1", got_data[1], 32'h91);
    check("t6_new_last", {31'b0, got_last[1]}, 32'd1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_stream_tx.md
# slave_stream_tx

Source-side transmitter that drives one slave port of the two-slave arbiter (slv0 or slv1). It accepts a transfer descriptor (mode, word count), pulls pixel words from an upstream stream into a small FIFO, and presents them on the slave interface with mode / data_valid / proc_valid / data while honouring the arbiter's ready. One instance sits in front of each arbiter slave input.

## Interface
- DW, 32, pixel/data word width
- DEPTH, 4, internal FIFO depth (power of two, ≥2)
- LENW, 16, width of transfer length counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  single-cycle transfer start request
- cfg_mode  in  2  transfer mode; 2'b00 means no request
- cfg_len  in  LENW  words in transfer
- pix_valid  in  1  upstream word valid
- pix_data  in  DW  upstream word
- pix_ready  out  1  upstream word accepted when pix_valid & pix_ready
- slv_mode  out  2  mode presented to arbiter (non-zero = requesting)
- slv_data_valid  out  1  slv_data holds a valid word
- slv_proc_valid  out  1  marks last word of transfer
- slv_data  out  DW  word to arbiter
- slv_ready  in  1  arbiter grant/accept
- mstr0_cmplt  in  1  master completion; terminates current transfer
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of transfer
- aborted  out  1  valid with done; 1 if ended by mstr0_cmplt

## Operation
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0.
- States: IDLE, ACTIVE, FINISH, FLUSH.
- IDLE -> ACTIVE: cfg_start=1 with cfg_mode≠0 and cfg_len≠0; latch mode/len, clear in_cnt/out_cnt. Otherwise cfg_start ignored. cfg_start in any non-IDLE state ignored.
- ACTIVE: slv_mode = latched mode. pix_ready = (fifo_count < DEPTH) && (in_cnt < len), from registered state only (no combinational path from slv_ready). Push increments in_cnt.
- Output: FIFO head is first-word-fall-through; slv_data_valid = FIFO not empty; slv_data = head. A word transfers on a rising edge where slv_data_valid & slv_ready; pop and out_cnt+1. slv_proc_valid = slv_data_valid && (out_cnt == len-1).
- Data/valid held stable until accepted; valid never drops without a transfer except on FLUSH/reset.
- Last word accepted -> FINISH: slv_mode=0, done=1, aborted=0, one cycle -> IDLE.
- mstr0_cmplt=1 in ACTIVE without a last-word transfer on that edge -> FLUSH: slv_mode=0, slv_data_valid=0, pix_ready=0, FIFO pointers cleared; done=1, aborted=1; one cycle -> IDLE.
- mstr0_cmplt coincident with last-word transfer: normal completion (aborted=0). mstr0_cmplt in IDLE/FINISH/FLUSH ignored.
- Arithmetic: counters LENW bits, unsigned; max transfer 2^LENW-1 words. FIFO count log2(DEPTH)+1 bits; pointers log2(DEPTH) bits, natural wrap.
- Simultaneous push and pop: both occur, count unchanged. Push when full impossible by pix_ready rule.
- Reset asserted mid-transfer: immediate return to reset values, no done pulse.

## Timing
- Start: cfg_start at edge N -> busy, slv_mode valid from N+1; pix_ready may be high from N+1.
- Upstream word pushed at edge M -> slv_data_valid high from M+1 (1-cycle latency).
- Sustained throughput one word/cycle when pix_valid and slv_ready both held high.
- Last-word transfer at edge L -> done pulse in cycle L+1; busy low from L+2.
- mstr0_cmplt sampled at edge A -> slv_mode=0, valid=0 from A+1; done/aborted in A+1; IDLE from A+2.

## Structure
- Package slave_tx_pkg: state enum (IDLE, ACTIVE, FINISH, FLUSH), MODE_NONE=2'b00 constant.
- Sub-module sync_fifo (DW, DEPTH params; push, pop, flush, head, count, empty, full); FSM and counters in top.

## Test plan
- Mode 2'b01, len 4, pix_valid and slv_ready always high, data 0x10..0x13 -> four transfers on consecutive cycles, proc_valid only with 0x13, done=1 aborted=0, busy low 2 cycles after last.
- slv_ready held low 10 cycles, len 8 -> exactly DEPTH=4 words pushed, pix_ready low, slv_data stable 0x10; then release -> all 8 delivered in order.
- cfg_start with mode 2'b00 or len 0 -> stays IDLE, slv_mode=0, no done.
- mstr0_cmplt after 2 of 6 words delivered -> slv_mode/valid 0 next cycle, done=1 aborted=1, new start then delivers fresh data with no stale words.
- mstr0_cmplt on same edge as last-word transfer (len 3) -> done=1, aborted=0.
- rst_n low mid-transfer (word 2 of 5) -> all outputs 0 asynchronously, no done; after release new len-2 transfer completes normally.
